ivt_region_guard: RTL and testbench
===================================

# ivt_region_guard

Parametrised successor of the single-window IVT write guard in the VRASED hardware monitor. It watches CPU data writes and DMA accesses against NREG independently enabled protected address windows. It also watches for changes to the executable-region bounds. It emits a registered `exec` flag that is granted only when execution enters at `ER_min` with no tampering, plus sticky per-region violation flags and a saturating abort counter for the attestation report.

## Interface
Parameters:
- `AW`, 16: address width of pc, data, DMA and bound buses.
- `NREG`, 2: number of protected windows (1..8).
- `CNTW`, 8: abort counter width.

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `puc_rst` in 1: asynchronous, active-high reset.
- `pc` in AW: current program counter.
- `data_addr` in AW: CPU data address.
- `data_en` in 1: CPU data write enable.
- `dma_addr` in AW: DMA address.
- `dma_en` in 1: DMA access enable.
- `ER_min`, `ER_max` in AW: executable region bounds.
- `reg_min`, `reg_max` in NREG*AW: window bounds, flattened; region i occupies bits [i*AW +: AW].
- `reg_en` in NREG: per-window enable.
- `viol_clr` in 1: synchronous clear of `viol_flags` and `abort_cnt`.
- `exec` out 1: execution-valid flag, registered.
- `viol_flags` out NREG: sticky per-region hit record.
- `abort_cnt` out CNTW: saturating count of EXEC->ABORT transitions.

## Operation
- Window hit i: `reg_en[i]` && ((`data_en` && `reg_min[i]` <= `data_addr` <= `reg_max[i]`) || (`dma_en` && `reg_min[i]` <= `dma_addr` <= `reg_max[i]`)).
  - All comparisons are unsigned and inclusive.
  - A window with min > max never hits.
- `hit_any` = OR of all window hits.
- `er_chg`: `ER_min` or `ER_max` differs from its registered copy of the previous cycle. The copies load from the inputs every cycle and reset to 0.
- `change` = `hit_any` || `er_chg`.
- FSM states: ABORT (reset), EXEC.
  - ABORT -> EXEC: `pc == ER_min` && !`change`.
  - EXEC -> ABORT: `change`. Also the pc-bound violation when PC_BOUND_EN is defined.
  - Otherwise the state holds.
- `exec` next value: 1 if the next state is EXEC, else 0. `exec` equals the registered state.
- `viol_flags[i]` sets on window hit i in any state. It clears only on `viol_clr` or reset. If set and clear occur in the same cycle, set wins.
- `abort_cnt` increments on each EXEC->ABORT transition and saturates at all-ones. `viol_clr` zeroes it; increment wins if simultaneous, and the result is 1.
- Simultaneous `pc == ER_min` and `change` in ABORT: the FSM stays in ABORT.

## Timing
- Reset values:
  - state ABORT.
  - `exec` 0.
  - `viol_flags` 0.
  - `abort_cnt` 0.
  - ER copies 0.
  - prev-pc register 0.
- Latency: a condition sampled at edge n is visible on outputs after edge n (1 cycle). No combinational input-to-output path.
- The first cycle after reset release sees `er_chg` if the ER bounds are nonzero, so a same-cycle entry at `ER_min` is rejected. Entry succeeds on the next `pc == ER_min`.
- Reset asserted mid-EXEC: `exec` drops asynchronously to 0. No counter increment.

## Configuration
- `PC_BOUND_EN` defined:
  - In EXEC, pc outside [`ER_min`, `ER_max`] forces ABORT, unless the previous-cycle pc equals `ER_max` (legal exit).
  - After a legal exit the FSM moves to ABORT without incrementing `abort_cnt`.
  - Requires a prev-pc register.
- `PC_BOUND_EN` undefined: pc is checked only for entry. The prev-pc register and the bound comparators are not built.

## Structure
- Shared package `ivt_guard_pkg`:
  - state encoding constants ABORT=1'b0... (no: ABORT=1'b1, EXEC=1'b0, matching the existing monitor).
  - default AW/NREG/CNTW.
- Sub-module `region_cmp`: one per window via generate. Inputs are both addresses, both enables and one window; output is the hit bit.
- Top-level holds the FSM, ER-change detection, flags and counter.

## Test plan
- Reset, then hold `ER_min`=0xE000 stable, then pc=0xE000 -> `exec`=1 one cycle later. `viol_flags`=0.
- In EXEC, `data_en`=1 with `data_addr`=0xFFE0 inside window 0 [0xFFE0,0xFFFF] -> `exec`=0 next cycle, `viol_flags[0]`=1, `abort_cnt`=1.
- `dma_en`=1 with `dma_addr`=0x0200 in window 1, but `reg_en[1]`=0 -> no abort, `viol_flags`=0.
- In EXEC, change `ER_max` from 0xE0FF to 0xE1FF -> `exec`=0 next cycle. Re-entry at `ER_min` two cycles later -> `exec`=1.
- Force 300 aborts with CNTW=8 -> `abort_cnt`=255. Pulse `viol_clr` -> 0.
- With PC_BOUND_EN:
  - pc jumps 0xE010 -> 0x4000 -> `exec`=0, `abort_cnt`+1.
  - pc 0xE0FF (`ER_max`) -> 0x4000 -> `exec`=0, `abort_cnt` unchanged.

Source files
------------

// File: rtl/ivt_region_guard_pkg.sv
// rtl/ivt_region_guard_pkg.sv - shared state encoding and default sizes for the IVT region guard
package ivt_guard_pkg;

    localparam int AW_DEF   = 16;
    localparam int NREG_DEF = 2;
    localparam int CNTW_DEF = 8;

    // Encoding kept identical to the original single-window monitor.
    typedef enum logic {
        EXEC  = 1'b0,
        ABORT = 1'b1
    } state_e;

endpackage

// File: rtl/ivt_region_guard_if.sv
// rtl/ivt_region_guard_if.sv - CPU/DMA observation bus and guard status outputs
import ivt_guard_pkg::*;

interface ivt_region_guard_if #(
    parameter int AW   = AW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int CNTW = CNTW_DEF
);
    logic [AW-1:0]      pc;
    logic [AW-1:0]      data_addr;
    logic               data_en;
    logic [AW-1:0]      dma_addr;
    logic               dma_en;
    logic [AW-1:0]      ER_min;
    logic [AW-1:0]      ER_max;
    logic [NREG*AW-1:0] reg_min;
    logic [NREG*AW-1:0] reg_max;
    logic [NREG-1:0]    reg_en;
    logic               viol_clr;
    logic               exec;
    logic [NREG-1:0]    viol_flags;
    logic [CNTW-1:0]    abort_cnt;

    modport master (
        output pc, data_addr, data_en, dma_addr, dma_en, ER_min, ER_max,
               reg_min, reg_max, reg_en, viol_clr,
        input  exec, viol_flags, abort_cnt
    );

    modport slave (
        input  pc, data_addr, data_en, dma_addr, dma_en, ER_min, ER_max,
               reg_min, reg_max, reg_en, viol_clr,
        output exec, viol_flags, abort_cnt
    );
endinterface

// File: rtl/ivt_region_guard_region_cmp.sv
// rtl/ivt_region_guard_region_cmp.sv - inclusive unsigned window hit for one protected region
module region_cmp #(
    parameter int AW = 16
) (
    input  logic [AW-1:0] data_addr,
    input  logic          data_en,
    input  logic [AW-1:0] dma_addr,
    input  logic          dma_en,
    input  logic [AW-1:0] win_min,
    input  logic [AW-1:0] win_max,
    input  logic          win_en,
    output logic          hit
);
    logic data_in;
    logic dma_in;

    // An inverted window (min > max) can never satisfy both bounds, so it never hits.
    assign data_in = (data_addr >= win_min) && (data_addr <= win_max);
    assign dma_in  = (dma_addr >= win_min) && (dma_addr <= win_max);
    assign hit     = win_en && ((data_en && data_in) || (dma_en && dma_in));
endmodule

// File: rtl/ivt_region_guard.sv
// rtl/ivt_region_guard.sv - multi-window IVT guard: exec FSM, ER-change detect, sticky flags, abort counter
// Optional PC_BOUND_EN: abort when pc leaves [ER_min, ER_max] except on a legal exit from ER_max.
module ivt_region_guard
    import ivt_guard_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input logic               clk,
    input logic               puc_rst,
    ivt_region_guard_if.slave bus
);
    state_e          state_q, state_d;
    logic            exec_q, exec_d;
    logic [AW-1:0]   er_min_q, er_max_q;
    logic [NREG-1:0] flags_q, flags_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [NREG-1:0] hit;
    logic            hit_any, er_chg, change, abort_inc;
    logic            pc_out, legal_exit;

    for (genvar i = 0; i < NREG; i++) begin : g_win
        region_cmp #(.AW(AW)) u_cmp (
            .data_addr (bus.data_addr),
            .data_en   (bus.data_en),
            .dma_addr  (bus.dma_addr),
            .dma_en    (bus.dma_en),
            .win_min   (bus.reg_min[i*AW +: AW]),
            .win_max   (bus.reg_max[i*AW +: AW]),
            .win_en    (bus.reg_en[i]),
            .hit       (hit[i])
        );
    end

    assign hit_any = |hit;
    assign er_chg  = (bus.ER_min != er_min_q) || (bus.ER_max != er_max_q);
    assign change  = hit_any || er_chg;

`ifdef PC_BOUND_EN
    logic [AW-1:0] prev_pc_q;

    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) prev_pc_q <= '0;
        else         prev_pc_q <= bus.pc;
    end

    assign pc_out     = (bus.pc < bus.ER_min) || (bus.pc > bus.ER_max);
    assign legal_exit = (prev_pc_q == bus.ER_max);
`else
    assign pc_out     = 1'b0;
    assign legal_exit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        abort_inc = 1'b0;
        case (state_q)
            ABORT: if ((bus.pc == bus.ER_min) && !change) state_d = EXEC;
            EXEC: begin
                if (change || pc_out) begin
                    state_d   = ABORT;
                    // Leaving through ER_max is a normal return, not an attack.
                    abort_inc = change || !legal_exit;
                end
            end
            default: state_d = ABORT;
        endcase
    end

    always_comb begin
        exec_d  = (state_d == EXEC);
        flags_d = (bus.viol_clr ? '0 : flags_q) | hit;
        cnt_d   = bus.viol_clr ? '0 : cnt_q;
        if (abort_inc) begin
            if (bus.viol_clr)         cnt_d = CNTW'(1);
            else if (~&cnt_q)         cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q  <= ABORT;
            exec_q   <= 1'b0;
            er_min_q <= '0;
            er_max_q <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            exec_q   <= exec_d;
            er_min_q <= bus.ER_min;
            er_max_q <= bus.ER_max;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.exec       = exec_q;
    assign bus.viol_flags = flags_q;
    assign bus.abort_cnt  = cnt_q;
endmodule

// File: tb/tb_ivt_region_guard.sv
// tb/tb_ivt_region_guard.sv - directed self-checking bench for ivt_region_guard
module tb_ivt_region_guard;
    logic clk;
    logic puc_rst;
    int   n_cmp;
    int   n_bad;

    ivt_region_guard_if #(.AW(16), .NREG(2), .CNTW(8)) bus ();

    ivt_region_guard #(.AW(16), .NREG(2), .CNTW(8)) dut (
        .clk     (clk),
        .puc_rst (puc_rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        puc_rst            = 1'b1;
        bus.pc             = 16'h0000;
        bus.data_addr      = 16'h0000;
        bus.data_en        = 1'b0;
        bus.dma_addr       = 16'h0000;
        bus.dma_en         = 1'b0;
        bus.ER_min         = 16'hE000;
        bus.ER_max         = 16'hE0FF;
        bus.reg_min        = {16'h0200, 16'hFFE0};
        bus.reg_max        = {16'h02FF, 16'hFFFF};
        bus.reg_en         = 2'b01;
        bus.viol_clr       = 1'b0;

        tick(); tick();
        check("rst_exec", 32'(bus.exec), 32'd0);
        check("rst_flags", 32'(bus.viol_flags), 32'd0);
        check("rst_cnt", 32'(bus.abort_cnt), 32'd0);

        puc_rst = 1'b0;
        bus.pc  = 16'hE000;
        tick();
        check("entry_after_rst_rejected", 32'(bus.exec), 32'd0);
        tick();
        check("entry_exec", 32'(bus.exec), 32'd1);
        check("entry_flags", 32'(bus.viol_flags), 32'd0);

        bus.pc = 16'hE010; bus.dma_en = 1'b1; bus.dma_addr = 16'h0200;
        tick();
        check("dma_disabled_exec", 32'(bus.exec), 32'd1);
        check("dma_disabled_flags", 32'(bus.viol_flags), 32'd0);
        bus.dma_en = 1'b0;

        bus.data_en = 1'b1; bus.data_addr = 16'hFFE0;
        tick();
        check("data_hit_exec", 32'(bus.exec), 32'd0);
        check("data_hit_flags", 32'(bus.viol_flags), 32'd1);
        check("data_hit_cnt", 32'(bus.abort_cnt), 32'd1);
        bus.data_en = 1'b0;

        bus.viol_clr = 1'b1;
        tick();
        check("clr_flags", 32'(bus.viol_flags), 32'd0);
        check("clr_cnt", 32'(bus.abort_cnt), 32'd0);
        bus.viol_clr = 1'b0;

        bus.data_en = 1'b1; bus.data_addr = 16'hFFDF;
        tick();
        check("below_min_flags", 32'(bus.viol_flags), 32'd0);
        bus.data_addr = 16'hFFFF;
        tick();
        check("at_max_flags", 32'(bus.viol_flags), 32'd1);
        check("abort_hit_cnt", 32'(bus.abort_cnt), 32'd0);
        bus.viol_clr = 1'b1;
        tick();
        check("set_wins_flags", 32'(bus.viol_flags), 32'd1);
        bus.data_en = 1'b0;
        tick();
        check("clr_only_flags", 32'(bus.viol_flags), 32'd0);
        bus.viol_clr = 1'b0;

        bus.pc = 16'hE000;
        tick();
        check("reentry_exec", 32'(bus.exec), 32'd1);
        bus.pc = 16'hE010; bus.ER_max = 16'hE1FF;
        tick();
        check("er_chg_exec", 32'(bus.exec), 32'd0);
        check("er_chg_cnt", 32'(bus.abort_cnt), 32'd1);
        tick();
        check("er_chg_hold", 32'(bus.exec), 32'd0);
        bus.pc = 16'hE000;
        tick();
        check("er_reentry_exec", 32'(bus.exec), 32'd1);

        bus.data_en = 1'b1; bus.data_addr = 16'hFFF0;
        tick();
        check("hit_at_ermin_exec", 32'(bus.exec), 32'd0);
        check("hit_at_ermin_cnt", 32'(bus.abort_cnt), 32'd2);
        tick();
        check("entry_blocked_exec", 32'(bus.exec), 32'd0);
        check("entry_blocked_cnt", 32'(bus.abort_cnt), 32'd2);
        bus.data_en = 1'b0;
        tick();
        check("entry_unblocked_exec", 32'(bus.exec), 32'd1);

        bus.viol_clr = 1'b1;
        tick();
        check("clr_in_exec_cnt", 32'(bus.abort_cnt), 32'd0);
        check("clr_in_exec_exec", 32'(bus.exec), 32'd1);
        bus.viol_clr = 1'b0;

        bus.reg_en = 2'b11;
        bus.reg_min[31:16] = 16'h0300; bus.reg_max[31:16] = 16'h0200;
        bus.dma_en = 1'b1; bus.dma_addr = 16'h0250;
        tick();
        check("inverted_win_exec", 32'(bus.exec), 32'd1);
        check("inverted_win_flags", 32'(bus.viol_flags), 32'd0);
        bus.reg_min[31:16] = 16'h0200; bus.reg_max[31:16] = 16'h02FF;
        bus.dma_addr = 16'h02FF;
        tick();
        check("dma_hit_exec", 32'(bus.exec), 32'd0);
        check("dma_hit_flags", 32'(bus.viol_flags), 32'd2);
        check("dma_hit_cnt", 32'(bus.abort_cnt), 32'd1);
        bus.dma_en = 1'b0;

        bus.data_addr = 16'hFFE0;
        for (int i = 0; i < 300; i++) begin
            bus.pc = 16'hE000;
            tick();
            bus.data_en = 1'b1;
            tick();
            bus.data_en = 1'b0;
        end
        check("sat_cnt", 32'(bus.abort_cnt), 32'd255);
        check("sat_flags", 32'(bus.viol_flags), 32'd3);

        tick();
        check("sat_reentry_exec", 32'(bus.exec), 32'd1);
        bus.data_en = 1'b1; bus.viol_clr = 1'b1;
        tick();
        check("inc_wins_cnt", 32'(bus.abort_cnt), 32'd1);
        check("inc_wins_flags", 32'(bus.viol_flags), 32'd1);
        bus.data_en = 1'b0;
        tick();
        check("clr_after_sat_cnt", 32'(bus.abort_cnt), 32'd0);
        bus.viol_clr = 1'b0;

        tick();
        check("pcb_entry_exec", 32'(bus.exec), 32'd1);
        bus.pc = 16'hE010;
        tick();
        check("pcb_inside_exec", 32'(bus.exec), 32'd1);
        bus.pc = 16'h4000;
        tick();
`ifdef PC_BOUND_EN
        check("pcb_jump_exec", 32'(bus.exec), 32'd0);
        check("pcb_jump_cnt", 32'(bus.abort_cnt), 32'd1);
        bus.pc = 16'hE000;
        tick();
        check("pcb_reentry_exec", 32'(bus.exec), 32'd1);
        bus.pc = 16'hE1FF;
        tick();
        bus.pc = 16'h4000;
        tick();
        check("pcb_legal_exit_exec", 32'(bus.exec), 32'd0);
        check("pcb_legal_exit_cnt", 32'(bus.abort_cnt), 32'd1);
`else
        check("nopcb_jump_exec", 32'(bus.exec), 32'd1);
        check("nopcb_jump_cnt", 32'(bus.abort_cnt), 32'd0);
`endif
        bus.pc = 16'hE000;
        tick();
        check("pre_rst_exec", 32'(bus.exec), 32'd1);
        #3 puc_rst = 1'b1;
        #1;
        check("async_rst_exec", 32'(bus.exec), 32'd0);
        check("async_rst_cnt", 32'(bus.abort_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
